demux18_regfile_32bit: RTL and testbench

Eight-entry, 32-bit register bank whose write side is a 1-to-8 demultiplexer: a 3-bit write select is decoded one-hot and steers the 32-bit write word into exactly one register. It is the write end of the 8:1 32-bit selection path. Two independent read ports, each built on an 8:1 32-bit mux selection, read the registers back. It sits in the datapath between the ALU result bus and the ALU operand inputs, and is the storage for the single-cycle datapath.

---
 rtl/demux18_regfile_32bit.sv | 72 +++++++
 tb/tb_demux18_regfile_32bit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/demux18_regfile_32bit.sv
// 8x32 register bank: one-hot decoded write port, two combinational read ports.
// Writes land on the clock edge; reads are 0-cycle with no write bypass; always ready.
module demux18_regfile_32bit (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [2:0]  wsel,
  input  logic [31:0] wdata,
  input  logic [2:0]  rsel_a,
  input  logic [2:0]  rsel_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  output logic [7:0]  wr_onehot,
  output logic [7:0]  written,
  output logic [7:0]  wr_count
);

  logic [7:0]  dec;
  logic [31:0] regs_q [1:7];
  logic [31:0] regs_d [1:7];
  logic [31:0] bank   [8];
  logic [7:0]  onehot_q, onehot_d;
  logic [7:0]  written_q, written_d;
  logic [7:0]  count_q, count_d;

  always_comb begin
    dec = 8'h00;
    if (we) dec = 8'h01 << wsel;
  end

  // Register 0 has no storage; a select of 0 still feeds the bookkeeping below.
  always_comb begin
    for (int i = 1; i < 8; i++) begin
      regs_d[i] = dec[i] ? wdata : regs_q[i];
    end
    onehot_d  = dec;
    written_d = written_q | dec;
    count_d   = count_q + {7'd0, we};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 8; i++) begin
        regs_q[i] <= 32'h0;
      end
      onehot_q  <= 8'h00;
      written_q <= 8'h00;
      count_q   <= 8'h00;
    end else begin
      for (int i = 1; i < 8; i++) begin
        regs_q[i] <= regs_d[i];
      end
      onehot_q  <= onehot_d;
      written_q <= written_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    bank[0] = 32'h0;
    for (int i = 1; i < 8; i++) begin
      bank[i] = regs_q[i];
    end
  end

  assign rdata_a   = bank[rsel_a];
  assign rdata_b   = bank[rsel_b];
  assign wr_onehot = onehot_q;
  assign written   = written_q;
  assign wr_count  = count_q;

endmodule

// File: tb/tb_demux18_regfile_32bit.sv
// Bench for demux18_regfile_32bit: per-cycle model compare plus directed literal checks.
module tb_demux18_regfile_32bit;

  logic        clk;
  logic        reset;
  logic        we;
  logic [2:0]  wsel;
  logic [31:0] wdata;
  logic [2:0]  rsel_a;
  logic [2:0]  rsel_b;
  logic [31:0] rdata_a;
  logic [31:0] rdata_b;
  logic [7:0]  wr_onehot;
  logic [7:0]  written;
  logic [7:0]  wr_count;

  int vectors;
  int miscompares;
  bit chk_en;

  logic [31:0] m_reg [8];
  logic [7:0]  m_written;
  logic [7:0]  m_onehot;
  int          m_count;

  demux18_regfile_32bit dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .wsel      (wsel),
    .wdata     (wdata),
    .rsel_a    (rsel_a),
    .rsel_b    (rsel_b),
    .rdata_a   (rdata_a),
    .rdata_b   (rdata_b),
    .wr_onehot (wr_onehot),
    .written   (written),
    .wr_count  (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the bank's behaviour stated directly in terms of its rules.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) m_reg[i] = 32'h0;
      m_written = 8'h00;
      m_onehot  = 8'h00;
      m_count   = 0;
    end else begin
      m_onehot = 8'h00;
      if (we) begin
        m_onehot[wsel]  = 1'b1;
        m_written[wsel] = 1'b1;
        m_count         = (m_count + 1) % 256;
        if (wsel != 3'd0) m_reg[wsel] = wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model rdata_a", rdata_a, m_reg[rsel_a]);
      check("model rdata_b", rdata_b, m_reg[rsel_b]);
      check("model wr_onehot", {24'd0, wr_onehot}, {24'd0, m_onehot});
      check("model written", {24'd0, written}, {24'd0, m_written});
      check("model wr_count", {24'd0, wr_count}, 32'(m_count));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0; miscompares = 0; chk_en = 1'b0;
    reset = 1'b1; we = 1'b0; wsel = 3'd0; wdata = 32'h0; rsel_a = 3'd0; rsel_b = 3'd0;

    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;

    // Reset state and full read sweep.
    check("reset written", {24'd0, written}, 32'h0);
    check("reset wr_count", {24'd0, wr_count}, 32'h0);
    check("reset wr_onehot", {24'd0, wr_onehot}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      rsel_a = 3'(i);
      rsel_b = 3'(7 - i);
      #1;
      check("reset read a", rdata_a, 32'h0);
      check("reset read b", rdata_b, 32'h0);
      tick();
    end

    // Fill registers 1..7 back to back.
    for (int i = 1; i < 8; i++) begin
      we = 1'b1; wsel = 3'(i); wdata = 32'h11111111 * i;
      tick();
      check("fill wr_onehot", {24'd0, wr_onehot}, 32'h1 << i);
    end
    we = 1'b0;
    check("fill written", {24'd0, written}, 32'h000000FE);
    check("fill wr_count", {24'd0, wr_count}, 32'd7);
    for (int i = 0; i < 8; i++) begin
      rsel_a = 3'(i);
      rsel_b = 3'(i);
      #1;
      check("fill read a", rdata_a, 32'h11111111 * i);
      check("fill read b", rdata_b, 32'h11111111 * i);
    end
    tick();

    // Register 0 write is counted but never stored.
    we = 1'b1; wsel = 3'd0; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0;
    check("r0 wr_onehot", {24'd0, wr_onehot}, 32'h01);
    check("r0 written", {24'd0, written}, 32'hFF);
    check("r0 wr_count", {24'd0, wr_count}, 32'd8);
    rsel_a = 3'd0; rsel_b = 3'd0;
    #1;
    check("r0 read a", rdata_a, 32'h0);
    check("r0 read b", rdata_b, 32'h0);
    tick();
    check("r0 onehot clears", {24'd0, wr_onehot}, 32'h0);

    // Same-cycle read of a register being written returns the old value.
    we = 1'b1; wsel = 3'd3; wdata = 32'hAAAA5555;
    tick();
    wdata = 32'h12345678; rsel_a = 3'd3; rsel_b = 3'd3;
    #1;
    check("rw old a", rdata_a, 32'hAAAA5555);
    check("rw old b", rdata_b, 32'hAAAA5555);
    tick();
    we = 1'b0;
    check("rw new a", rdata_a, 32'h12345678);
    check("rw new b", rdata_b, 32'h12345678);
    check("rw wr_count", {24'd0, wr_count}, 32'd10);

    // we=0 leaves state alone.
    wsel = 3'd5; wdata = 32'hFFFFFFFF; rsel_a = 3'd5;
    tick();
    check("we0 reg5", rdata_a, 32'h55555555);
    check("we0 wr_count", {24'd0, wr_count}, 32'd10);

    // Reset wins over a simultaneous write.
    reset = 1'b1; we = 1'b1; wsel = 3'd2; wdata = 32'hCAFEF00D; rsel_a = 3'd2; rsel_b = 3'd5;
    tick();
    reset = 1'b0; we = 1'b0;
    check("rst prio written", {24'd0, written}, 32'h0);
    check("rst prio wr_count", {24'd0, wr_count}, 32'h0);
    check("rst prio wr_onehot", {24'd0, wr_onehot}, 32'h0);
    check("rst prio reg2", rdata_a, 32'h0);
    check("rst prio reg5", rdata_b, 32'h0);
    tick();

    // Counter wrap: 256 writes return to zero, the next gives one.
    for (int k = 0; k < 256; k++) begin
      we = 1'b1; wsel = 3'(k % 8); wdata = 32'h01010101 * k;
      rsel_a = 3'((k + 3) % 8); rsel_b = 3'(k % 8);
      tick();
    end
    check("wrap wr_count 256", {24'd0, wr_count}, 32'd0);
    wsel = 3'd6; wdata = 32'h600DD00D;
    tick();
    we = 1'b0;
    check("wrap wr_count 257", {24'd0, wr_count}, 32'd1);
    rsel_a = 3'd6;
    #1;
    check("wrap reg6", rdata_a, 32'h600DD00D);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
